// File: rtl/ah_div_pipelined_param.sv
// Pipelined restoring divider: input stage, WIDTH one-bit stages, output stage.
// A single global advance signal stalls every stage together when the output is blocked.
module ah_div_pipelined_param #(
   parameter int WIDTH = 32,
   parameter int TAG_W = 4
) (
   input  logic             clk,
   input  logic             rst,
   input  logic             in_valid,
   output logic             in_ready,
   input  logic             in_signed,
   input  logic [WIDTH-1:0] dividend,
   input  logic [WIDTH-1:0] divisor,
   input  logic [TAG_W-1:0] in_tag,
   output logic             out_valid,
   input  logic             out_ready,
   output logic [WIDTH-1:0] quotient,
   output logic [WIDTH-1:0] remainder,
   output logic [TAG_W-1:0] out_tag,
   output logic             div_by_zero,
   output logic             overflow
);

   localparam logic [WIDTH-1:0] MIN_VAL = {1'b1, {(WIDTH-1){1'b0}}};

   typedef struct packed {
      logic             v;
      logic [TAG_W-1:0] tag;
      logic [WIDTH-1:0] quo;
      logic [WIDTH-1:0] rem;
      logic [WIDTH-1:0] den;
      logic             neg_q;
      logic             neg_r;
      logic             dbz;
      logic             ovf;
   } stage_t;

   // st[0] is the input stage; st[k] holds the state after k quotient bits resolved
   stage_t st [0:WIDTH];
   stage_t in_st;
   logic   advance;
   logic   a_neg;
   logic   b_neg;
   logic [WIDTH-1:0] fin_q;
   logic [WIDTH-1:0] fin_r;

   assign advance  = !out_valid | out_ready;
   assign in_ready = advance;

   // With a zero divisor both branches shift the same bits, so rem ends up as |dividend|
   function automatic stage_t div_step(input stage_t s);
      stage_t         n;
      logic [WIDTH:0] trial;
      n     = s;
      trial = {s.rem, s.quo[WIDTH-1]} - {1'b0, s.den};
      if (!trial[WIDTH]) begin
         n.rem = trial[WIDTH-1:0];
         n.quo = {s.quo[WIDTH-2:0], 1'b1};
      end else begin
         n.rem = {s.rem[WIDTH-2:0], s.quo[WIDTH-1]};
         n.quo = {s.quo[WIDTH-2:0], 1'b0};
      end
      return n;
   endfunction

   always_comb begin
      in_st       = '0;
      a_neg       = in_signed & dividend[WIDTH-1];
      b_neg       = in_signed & divisor[WIDTH-1];
      in_st.v     = in_valid;
      in_st.tag   = in_tag;
      in_st.quo   = a_neg ? -dividend : dividend;
      in_st.den   = b_neg ? -divisor : divisor;
      in_st.neg_q = a_neg ^ b_neg;
      in_st.neg_r = a_neg;
      in_st.dbz   = (divisor == '0);
      in_st.ovf   = in_signed & (dividend == MIN_VAL) & (divisor == '1);
   end

   always_comb begin
      fin_q = st[WIDTH].neg_q ? -st[WIDTH].quo : st[WIDTH].quo;
      fin_r = st[WIDTH].neg_r ? -st[WIDTH].rem : st[WIDTH].rem;
      if (st[WIDTH].dbz) begin
         fin_q = '1;
      end
      if (st[WIDTH].ovf) begin
         fin_q = MIN_VAL;
         fin_r = '0;
      end
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         for (int unsigned k = 0; k <= WIDTH; k++) begin
            st[k] <= '0;
         end
         out_valid   <= 1'b0;
         quotient    <= '0;
         remainder   <= '0;
         out_tag     <= '0;
         div_by_zero <= 1'b0;
         overflow    <= 1'b0;
      end else if (advance) begin
         st[0] <= in_st;
         for (int unsigned k = 1; k <= WIDTH; k++) begin
            st[k] <= div_step(st[k-1]);
         end
         out_valid   <= st[WIDTH].v;
         quotient    <= fin_q;
         remainder   <= fin_r;
         out_tag     <= st[WIDTH].tag;
         div_by_zero <= st[WIDTH].dbz;
         overflow    <= st[WIDTH].ovf;
      end
   end

endmodule

// File: tb/tb_ah_div_pipelined_param.sv
// Randomized scoreboard bench for ah_div_pipelined_param (WIDTH=32, TAG_W=4).
module tb_ah_div_pipelined_param;

   localparam int W  = 32;
   localparam int TW = 4;

   logic          clk = 1'b0;
   logic          rst;
   logic          in_valid;
   logic          in_ready;
   logic          in_signed;
   logic [W-1:0]  dividend;
   logic [W-1:0]  divisor;
   logic [TW-1:0] in_tag;
   logic          out_valid;
   logic          out_ready;
   logic [W-1:0]  quotient;
   logic [W-1:0]  remainder;
   logic [TW-1:0] out_tag;
   logic          div_by_zero;
   logic          overflow;

   ah_div_pipelined_param #(.WIDTH(W), .TAG_W(TW)) dut (
      .clk(clk), .rst(rst),
      .in_valid(in_valid), .in_ready(in_ready), .in_signed(in_signed),
      .dividend(dividend), .divisor(divisor), .in_tag(in_tag),
      .out_valid(out_valid), .out_ready(out_ready),
      .quotient(quotient), .remainder(remainder), .out_tag(out_tag),
      .div_by_zero(div_by_zero), .overflow(overflow)
   );

   always #5 clk = ~clk;

   typedef struct {
      logic [TW-1:0] tag;
      logic [W-1:0]  q;
      logic [W-1:0]  r;
      logic          dbz;
      logic          ovf;
   } exp_t;

   exp_t        scb[$];
   int unsigned n_cmp = 0;
   int unsigned n_bad = 0;
   logic        stall_prev = 1'b0;
   exp_t        held;
   logic        obs_ov;
   exp_t        obs;
   logic        last_acc;

   task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
      n_cmp++;
      if (got !== exp) begin
         n_bad++;
         $display("FAIL %s: got %0h expected %0h", tag, got, exp);
      end
   endtask

   // Reference: plain 64-bit arithmetic, C-style truncating division
   function automatic exp_t model(input logic sgn, input logic [W-1:0] a, input logic [W-1:0] b,
                                  input logic [TW-1:0] tag);
      exp_t   e;
      longint sa, sbv, qq, rr;
      e.tag = tag;
      e.dbz = 1'b0;
      e.ovf = 1'b0;
      if (b == 0) begin
         e.dbz = 1'b1;
         e.q   = '1;
         e.r   = a;
      end else if (sgn && a == 32'h8000_0000 && b == 32'hFFFF_FFFF) begin
         e.ovf = 1'b1;
         e.q   = a;
         e.r   = '0;
      end else begin
         if (sgn) begin
            sa  = longint'($signed(a));
            sbv = longint'($signed(b));
         end else begin
            sa  = longint'(a);
            sbv = longint'(b);
         end
         qq  = sa / sbv;
         rr  = sa % sbv;
         e.q = qq[W-1:0];
         e.r = rr[W-1:0];
      end
      return e;
   endfunction

   // One clock: sample outputs away from the edge, score handshakes, then cross the edge
   task automatic step();
      logic acc;
      logic pop;
      logic rst_now;
      exp_t e;
      #1;
      rst_now = rst;
      check("in_ready_rule", in_ready, !out_valid || out_ready);
      if (stall_prev) begin
         check("stall_valid", out_valid, 1);
         check("stall_q", quotient, held.q);
         check("stall_r", remainder, held.r);
         check("stall_tag", out_tag, held.tag);
         check("stall_flags", {div_by_zero, overflow}, {held.dbz, held.ovf});
      end
      obs_ov  = out_valid;
      obs.q   = quotient;
      obs.r   = remainder;
      obs.tag = out_tag;
      obs.dbz = div_by_zero;
      obs.ovf = overflow;
      acc = in_valid && in_ready && !rst_now;
      pop = out_valid && out_ready && !rst_now;
      if (pop) begin
         if (scb.size() == 0) begin
            check("spurious_result", 1, 0);
         end else begin
            e = scb.pop_front();
            check("quotient", quotient, e.q);
            check("remainder", remainder, e.r);
            check("out_tag", out_tag, e.tag);
            check("flags", {div_by_zero, overflow}, {e.dbz, e.ovf});
         end
      end
      stall_prev = out_valid && !out_ready && !rst_now;
      held       = obs;
      last_acc   = acc;
      if (acc) scb.push_back(model(in_signed, dividend, divisor, in_tag));
      @(posedge clk);
      #1;
      if (rst_now) scb.delete();
   endtask

   task automatic directed(input logic sgn, input logic [W-1:0] a, input logic [W-1:0] b,
                           input logic [TW-1:0] tag, input logic [W-1:0] eq,
                           input logic [W-1:0] er, input logic edbz, input logic eovf);
      int edges;
      in_valid  = 1'b1;
      in_signed = sgn;
      dividend  = a;
      divisor   = b;
      in_tag    = tag;
      out_ready = 1'b1;
      step();
      check("dir_accepted", last_acc, 1);
      in_valid = 1'b0;
      for (edges = 1; edges <= 100; edges++) begin
         step();
         if (obs_ov) break;
      end
      check("dir_latency", edges, W + 2);
      check("dir_q", obs.q, eq);
      check("dir_r", obs.r, er);
      check("dir_tag", obs.tag, tag);
      check("dir_flags", {obs.dbz, obs.ovf}, {edbz, eovf});
   endtask

   task automatic rand_operands();
      in_signed = 1'($urandom_range(0, 1));
      case ($urandom_range(0, 5))
         0: begin dividend = $urandom; divisor = '0; end
         1: begin dividend = 32'h8000_0000; divisor = 32'hFFFF_FFFF; end
         2: begin dividend = $urandom; divisor = 32'($urandom_range(1, 15)); end
         3: begin dividend = 32'($urandom_range(0, 20)); divisor = $urandom; end
         default: begin dividend = $urandom; divisor = $urandom; end
      endcase
   endtask

   initial begin
      #1_000_000;
      $display("FAIL watchdog: got timeout expected finish");
      $fatal(1, "watchdog expired");
   end

   initial begin
      int unsigned accepted;
      logic [TW-1:0] tagc;

      rst = 1'b1; in_valid = 1'b0; in_signed = 1'b0;
      dividend = '0; divisor = '0; in_tag = '0; out_ready = 1'b1;
      @(posedge clk);
      #1;
      repeat (2) step();
      check("rst_out_valid", out_valid, 0);
      check("rst_in_ready", in_ready, 1);
      check("rst_quotient", quotient, 0);
      check("rst_remainder", remainder, 0);
      check("rst_out_tag", out_tag, 0);
      check("rst_flags", {div_by_zero, overflow}, 2'b00);
      rst = 1'b0;

      directed(1'b0, 32'd100, 32'd7, 4'd3, 32'd14, 32'd2, 1'b0, 1'b0);
      directed(1'b1, 32'hFFFF_FFF9, 32'd2, 4'd4, 32'hFFFF_FFFD, 32'hFFFF_FFFF, 1'b0, 1'b0);
      directed(1'b0, 32'hFFFF_FFF9, 32'd2, 4'd5, 32'h7FFF_FFFC, 32'd1, 1'b0, 1'b0);
      directed(1'b1, 32'd5, 32'd0, 4'd6, 32'hFFFF_FFFF, 32'd5, 1'b1, 1'b0);
      directed(1'b0, 32'd5, 32'd0, 4'd7, 32'hFFFF_FFFF, 32'd5, 1'b1, 1'b0);
      directed(1'b1, 32'h8000_0000, 32'hFFFF_FFFF, 4'd8, 32'h8000_0000, 32'd0, 1'b0, 1'b1);

      accepted = 0;
      tagc     = '0;
      for (int c = 0; c < 6000 && accepted < 500; c++) begin
         in_valid  = ($urandom_range(0, 7) != 0);
         rand_operands();
         in_tag    = tagc;
         out_ready = ($urandom_range(0, 3) != 0);
         step();
         if (last_acc) begin
            tagc++;
            accepted++;
         end
      end
      check("random_accepted", accepted, 500);

      in_valid = 1'b0;
      for (int c = 0; c < 3000 && scb.size() > 0; c++) begin
         out_ready = 1'($urandom_range(0, 1));
         step();
      end
      out_ready = 1'b1;
      repeat (40) step();
      check("drain_empty", scb.size(), 0);

      for (int i = 0; i < 20; i++) begin
         in_valid = 1'b1;
         rand_operands();
         in_tag = 4'(i);
         step();
      end
      rst = 1'b1;
      rand_operands();
      step();
      rst      = 1'b0;
      in_valid = 1'b0;
      check("rst_flush_valid", out_valid, 0);
      repeat (60) step();
      directed(1'b0, 32'd1000, 32'd10, 4'd9, 32'd100, 32'd0, 1'b0, 1'b0);
      repeat (5) step();
      check("final_empty", scb.size(), 0);

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
      $finish;
   end

endmodule

// File: doc/ah_div_pipelined_param.md
AH_DIV_PIPELINED_PARAM -- requirements
Module: ah_div_pipelined_param

Interface
REQ-001 The block SHALL have parameter WIDTH, default 32, giving the operand, quotient and remainder width (legal range 4..64).
REQ-002 The block SHALL have parameter TAG_W, default 4, giving the width of the pass-through transaction tag (legal range 1..16).
REQ-003 The block SHALL have one clock; reset is synchronous and active-high.
REQ-004 clk  input  1  rising-edge clock for all state.
REQ-005 rst  input  1  synchronous active-high reset.
REQ-006 in_valid  input  1  operation offered this cycle.
REQ-007 in_ready  output  1  block accepts the operation this cycle.
REQ-008 in_signed  input  1  1 = two's-complement operands; 0 = unsigned operands.
REQ-009 dividend  input  WIDTH  numerator.
REQ-010 divisor  input  WIDTH  denominator.
REQ-011 in_tag  input  TAG_W  opaque ID returned with the result.
REQ-012 out_valid  output  1  result present.
REQ-013 out_ready  input  1  consumer accepts the result.
REQ-014 quotient  output  WIDTH  quotient.
REQ-015 remainder  output  WIDTH  remainder.
REQ-016 out_tag  output  TAG_W  tag of the result.
REQ-017 div_by_zero  output  1  divisor was zero.
REQ-018 overflow  output  1  signed MIN / -1 case.

Function
REQ-019 An operation SHALL be accepted on a rising edge with in_valid=1 and in_ready=1.
REQ-020 Pipeline structure SHALL be: 1 input stage (sign capture, absolute values, zero/overflow detect), then WIDTH restoring-division stages each resolving one quotient bit MSB-first, then 1 output stage (sign correction, special-case override).
REQ-021 Unstalled latency SHALL be WIDTH+2 cycles from acceptance to out_valid=1; throughput SHALL be one operation per cycle.
REQ-022 Stall SHALL be global: advance = !out_valid | out_ready; in_ready = advance; when advance=0 every stage, including valid bits and tags, SHALL hold.
REQ-023 Results SHALL leave in acceptance order; no result SHALL be lost or duplicated under any out_ready pattern.
REQ-024 Output fields SHALL stay stable while out_valid=1 and out_ready=0.
REQ-025 Division SHALL truncate toward zero; remainder SHALL take the sign of the dividend; for nonzero divisor, dividend = quotient*divisor + remainder (mod 2^WIDTH).
REQ-026 Signed mode negative-quotient sign SHALL equal dividend[MSB] XOR divisor[MSB]; unsigned mode SHALL ignore operand MSB as a sign.
REQ-027 Divisor zero SHALL give div_by_zero=1, quotient all ones, remainder = dividend, overflow=0, in both modes.
REQ-028 Signed mode with dividend = 2^(WIDTH-1) and divisor all ones SHALL give overflow=1, quotient = dividend, remainder = 0.
REQ-029 Pipeline bubbles (invalid slots) SHALL never produce out_valid=1.
REQ-030 in_ready SHALL be independent of in_valid (no combinational in_valid->in_ready path).

Reset
REQ-031 On a clock edge with rst=1, all stage valid bits, out_valid, div_by_zero and overflow SHALL clear to 0; quotient, remainder and out_tag SHALL clear to 0.
REQ-032 Reset asserted mid-operation SHALL discard all in-flight operations; none SHALL appear after rst deasserts.
REQ-033 During reset, in_ready SHALL read 1 (out_valid=0); operations offered while rst=1 SHALL be dropped.

Verification (WIDTH=32)
REQ-034 Unsigned 100/7, tag 3 -> after 34 cycles out_valid=1, quotient=14, remainder=2, out_tag=3, flags 0.
REQ-035 Signed 0xFFFFFFF9 (-7) / 2 -> quotient=0xFFFFFFFD, remainder=0xFFFFFFFF; same operands unsigned -> quotient=0x7FFFFFFC, remainder=1.
REQ-036 Divisor 0, dividend 5, signed and unsigned -> div_by_zero=1, quotient=0xFFFFFFFF, remainder=5.
REQ-037 Signed 0x80000000 / 0xFFFFFFFF -> overflow=1, quotient=0x80000000, remainder=0.
REQ-038 500 back-to-back random operations, random out_ready, tags incrementing -> all results in order, match reference model, none lost or duplicated, outputs stable while stalled.
REQ-039 rst pulsed for 1 cycle with 20 operations in flight -> out_valid=0 next cycle; no stale result emitted; the next accepted operation completes with correct latency.
